data_serializer: RTL and testbench
==================================

DATA_SERIALIZER -- requirements
Module: data_serializer

Interface
REQ-001 The block SHALL have one parameter: DATA_WIDTH, default 8, parallel word width; all requirements below use 8.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, i_CLEAR_B.
REQ-003 Port i_SSPCLKOUT SHALL be an input, 1 bit wide: serial clock; all state changes occur on its rising edge.
REQ-004 Port i_CLEAR_B SHALL be an input, 1 bit wide: asynchronous active-low reset.
REQ-005 Port i_TXVALID SHALL be an input, 1 bit wide: a transmit word is available on i_TXDATA (TX FIFO not empty).
REQ-006 Port i_TXDATA SHALL be an input, DATA_WIDTH bits wide: the parallel word to send, held stable while i_TXVALID=1.
REQ-007 Port o_TXREAD SHALL be an output, 1 bit wide: one-cycle pulse meaning the word on i_TXDATA was consumed (pop strobe).
REQ-008 Port o_SSPFSSOUT SHALL be an output, 1 bit wide: frame sync, high for exactly one cycle before each word's MSB.
REQ-009 Port o_SSPTXD SHALL be an output, 1 bit wide: serial data, MSB first.
REQ-010 Port o_SSPOE_B SHALL be an output, 1 bit wide: active-low pad output enable for o_SSPTXD.
REQ-011 Port o_BUSY SHALL be an output, 1 bit wide: high whenever the state is not IDLE.

Function
REQ-012 All outputs SHALL be registered and change only after the rising edge of i_SSPCLKOUT, or on reset.
REQ-013 The FSM SHALL have exactly four states: IDLE, SYNC, TX_LOOP and TX_LAST; any illegal encoding SHALL go to IDLE on the next edge.
REQ-014 In IDLE, the block SHALL hold o_SSPFSSOUT=0, o_SSPTXD=0, o_SSPOE_B=1 and o_TXREAD=0.
REQ-015 On an edge in IDLE with i_TXVALID=1, the block SHALL load i_TXDATA into the shift register and enter SYNC.
REQ-016 SYNC (cycle C0) SHALL last 1 cycle with o_SSPFSSOUT=1, o_SSPTXD=0, o_SSPOE_B=0 and o_TXREAD=1.
REQ-017 From SYNC the block SHALL enter TX_LOOP; TX_LOOP covers cycles C1..C7 and drives o_SSPTXD = bit7..bit1, one bit per cycle.
REQ-018 In TX_LOOP, a 3-bit down-counter SHALL be loaded with 7 at entry, decrement each cycle, and move the FSM to TX_LAST when the counter reaches 1.
REQ-019 TX_LAST (cycle C8) SHALL drive o_SSPTXD=bit0 and o_SSPOE_B=0.
REQ-020 On the edge entering TX_LAST, if i_TXVALID=1, the block SHALL capture i_TXDATA into a next-word buffer, assert o_TXREAD and o_SSPFSSOUT for C8, and go from TX_LAST to TX_LOOP.
REQ-021 The back-to-back frame period SHALL therefore be 8 cycles, with the frame sync coincident with the previous LSB; bit0 of the current word SHALL NOT be corrupted by the buffer load.
REQ-022 On the edge entering TX_LAST, if i_TXVALID=0, the block SHALL hold o_SSPFSSOUT=0 during C8 and go from TX_LAST to IDLE.
REQ-023 An isolated frame SHALL occupy 9 cycles (C0..C8) with o_SSPOE_B low throughout.
REQ-024 i_TXVALID SHALL be ignored in SYNC and in TX_LOOP cycles other than the one ending C7.
REQ-025 o_TXREAD SHALL pulse exactly once per word transmitted and never for two consecutive cycles.
REQ-026 Latency from sampling i_TXVALID=1 in IDLE to MSB on o_SSPTXD SHALL be 2 edges.

Reset
REQ-027 Asserting i_CLEAR_B low SHALL immediately force: state=IDLE, counter=0, shift register and buffer=0, o_SSPFSSOUT=0, o_SSPTXD=0, o_SSPOE_B=1, o_TXREAD=0, o_BUSY=0.
REQ-028 Reset mid-frame SHALL abort the frame; the partial word is dropped and no further o_TXREAD pulse is issued for it.
REQ-029 After reset deasserts, the first frame SHALL start only on an edge where i_TXVALID=1.

Verification
REQ-030 Single word 0xA5, i_TXVALID high for 1 cycle -> the bench SHALL check FSS=1 in C0, TXD=1,0,1,0,0,1,0,1 in C1..C8, one o_TXREAD in C0, OE_B low C0..C8, then IDLE.
REQ-031 Back-to-back 0x81 then 0x7E, valid held -> the bench SHALL check FSS=1 in C0 and in C8 of the first word, the second MSB=0 immediately after 0x81's LSB=1, 16 data bits over 17 cycles, and two o_TXREAD pulses 8 cycles apart.
REQ-032 Loopback into the SSP receiver on the same clock with words 0x00, 0xFF, 0x3C -> the bench SHALL check that the receiver outputs the identical words in order, each with one o_REQ.
REQ-033 i_CLEAR_B low during C4 of 0xF0 -> the bench SHALL check that outputs go to reset values asynchronously, no o_TXREAD follows, and the next word 0x55 transmits correctly.
REQ-034 i_TXVALID toggling during TX_LOOP C2..C6 -> the bench SHALL check that no o_TXREAD occurs and the frame data is unchanged.
REQ-035 i_TXVALID dropping at the C7 edge -> the bench SHALL check FSS=0 in C8, a return to IDLE, and OE_B=1 in the cycle after C8.

Source files
------------

// File: rtl/data_serializer.sv
// data_serializer: parallel-to-serial SSP-style transmitter.
// Pops words from a TX FIFO and shifts them out MSB first, with a one-cycle
// frame sync ahead of each word. Back-to-back words overlap the next frame
// sync with the current LSB, which gives an 8-cycle frame period.
//
// Ports:
//   i_SSPCLKOUT  serial clock; all state changes on its rising edge
//   i_CLEAR_B    asynchronous active-low reset
//   i_TXVALID    TX FIFO not empty
//   i_TXDATA     word at the head of the TX FIFO
//   o_TXREAD     one-cycle pop strobe for the TX FIFO
//   o_SSPFSSOUT  frame sync, high for one cycle before each MSB
//   o_SSPTXD     serial data, MSB first
//   o_SSPOE_B    active-low output enable for o_SSPTXD
//   o_BUSY       high whenever the FSM is not idle
module data_serializer #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_SSPCLKOUT,
  input  logic                  i_CLEAR_B,
  input  logic                  i_TXVALID,
  input  logic [DATA_WIDTH-1:0] i_TXDATA,
  output logic                  o_TXREAD,
  output logic                  o_SSPFSSOUT,
  output logic                  o_SSPTXD,
  output logic                  o_SSPOE_B,
  output logic                  o_BUSY
);

  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SYNC    = 2'd1;
  localparam logic [1:0] TX_LOOP = 2'd2;
  localparam logic [1:0] TX_LAST = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  chain_q, chain_d;
  logic                  fss_q, fss_d;
  logic                  txd_q, txd_d;
  logic                  oe_b_q, oe_b_d;
  logic                  txread_q, txread_d;
  logic                  busy_q, busy_d;

  // State and registered outputs
  always_ff @(posedge i_SSPCLKOUT or negedge i_CLEAR_B) begin
    if (!i_CLEAR_B) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shift_q  <= '0;
      buf_q    <= '0;
      chain_q  <= 1'b0;
      fss_q    <= 1'b0;
      txd_q    <= 1'b0;
      oe_b_q   <= 1'b1;
      txread_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      buf_q    <= buf_d;
      chain_q  <= chain_d;
      fss_q    <= fss_d;
      txd_q    <= txd_d;
      oe_b_q   <= oe_b_d;
      txread_q <= txread_d;
      busy_q   <= busy_d;
    end
  end

  // Next state; output values computed here are those for the coming cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    buf_d    = buf_q;
    chain_d  = chain_q;
    fss_d    = 1'b0;
    txd_d    = 1'b0;
    oe_b_d   = 1'b1;
    txread_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_TXVALID) begin
          shift_d  = i_TXDATA;
          state_d  = SYNC;
          fss_d    = 1'b1;
          oe_b_d   = 1'b0;
          txread_d = 1'b1;
        end
      end
      SYNC: begin
        state_d = TX_LOOP;
        cnt_d   = CNT_LOAD;
        txd_d   = shift_q[DATA_WIDTH-1];
        oe_b_d  = 1'b0;
      end
      TX_LOOP: begin
        oe_b_d = 1'b0;
        if (cnt_q == CNT_W'(1)) begin
          // Last loop cycle: decide now whether a word follows, so its frame
          // sync can share the LSB cycle. The word lands in buf_q, leaving
          // shift_q intact for bit0.
          state_d  = TX_LAST;
          cnt_d    = '0;
          txd_d    = shift_q[0];
          chain_d  = i_TXVALID;
          fss_d    = i_TXVALID;
          txread_d = i_TXVALID;
          if (i_TXVALID) begin
            buf_d = i_TXDATA;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          txd_d = shift_q[cnt_d];
        end
      end
      TX_LAST: begin
        chain_d = 1'b0;
        if (chain_q) begin
          state_d = TX_LOOP;
          shift_d = buf_q;
          cnt_d   = CNT_LOAD;
          txd_d   = buf_q[DATA_WIDTH-1];
          oe_b_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign o_TXREAD    = txread_q;
  assign o_SSPFSSOUT = fss_q;
  assign o_SSPTXD    = txd_q;
  assign o_SSPOE_B   = oe_b_q;
  assign o_BUSY      = busy_q;

endmodule

// File: tb/tb_data_serializer.sv
// Bench for data_serializer: frame-position reference model checked every
// cycle, a behavioural SSP receiver for loopback, and directed scenarios.
module tb_data_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       txvalid;
  logic [7:0] txdata;
  logic       rd, fss, txd, oe, busy;

  int n_tests = 0;
  int n_fail  = 0;
  bit done    = 1'b0;

  data_serializer #(.DATA_WIDTH(8)) dut (
    .i_SSPCLKOUT (clk),
    .i_CLEAR_B   (rst_n),
    .i_TXVALID   (txvalid),
    .i_TXDATA    (txdata),
    .o_TXREAD    (rd),
    .o_SSPFSSOUT (fss),
    .o_SSPTXD    (txd),
    .o_SSPOE_B   (oe),
    .o_BUSY      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: position within a frame (-1 idle, 0 = sync cycle,
  // 1..8 = data bits MSB..LSB) and whether a follow-on word was accepted.
  int         m_pos = -1;
  logic [7:0] m_word = '0;
  logic [7:0] m_next = '0;
  logic       m_chain = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos   = -1;
      m_chain = 1'b0;
    end else if (m_pos == -1) begin
      if (txvalid) begin
        m_pos  = 0;
        m_word = txdata;
      end
    end else if (m_pos == 7) begin
      m_chain = txvalid;
      m_next  = txdata;
      m_pos   = 8;
    end else if (m_pos == 8) begin
      if (m_chain) begin
        m_pos  = 1;
        m_word = m_next;
      end else begin
        m_pos = -1;
      end
      m_chain = 1'b0;
    end else begin
      m_pos++;
    end
  end

  // Expected {fss, txd, oe_b, txread, busy}
  function automatic logic [4:0] exp_out();
    if (m_pos < 0)  return 5'b00100;
    if (m_pos == 0) return 5'b10011;
    if (m_pos <= 7) return {1'b0, m_word[8-m_pos], 3'b001};
    return {m_chain, m_word[0], 1'b0, m_chain, 1'b1};
  endfunction

  // Per-cycle compare plus TXREAD bookkeeping
  int   cyc = 0;
  int   rd_cnt = 0;
  int   rd_cycles[$];
  logic prev_rd = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!done) begin
      check("cycle_outputs", 32'({fss, txd, oe, rd, busy}), 32'(exp_out()));
      if (rd) begin
        check("txread_not_consecutive", 32'(prev_rd), 32'(0));
        rd_cnt++;
        rd_cycles.push_back(cyc);
      end
    end
    prev_rd = rd;
  end

  // Behavioural SSP receiver on the same clock
  logic       rx_on = 1'b0;
  int         rx_n = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q[$];
  logic       rx_req = 1'b0;
  int         rx_req_cnt = 0;

  always @(negedge clk) begin
    rx_req = 1'b0;
    if (!rst_n) begin
      rx_on = 1'b0;
    end else begin
      if (rx_on) begin
        rx_sh = {rx_sh[6:0], txd};
        rx_n++;
        if (rx_n == 8) begin
          rx_q.push_back(rx_sh);
          rx_req = 1'b1;
          rx_req_cnt++;
          rx_on = 1'b0;
        end
      end
      if (fss) begin
        rx_on = 1'b1;
        rx_n  = 0;
      end
    end
  end

  // Sample point: just after the falling edge, all monitors settled
  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic tx_single(input logic [7:0] w, input string nm);
    logic [7:0] bits;
    logic       oe_ok;
    int         r0;
    r0      = rd_cnt;
    txvalid = 1'b1;
    txdata  = w;
    nxt();
    check({nm, "_c0_fss"}, 32'(fss), 32'(1));
    check({nm, "_c0_txread"}, 32'(rd), 32'(1));
    txvalid = 1'b0;
    txdata  = '0;
    bits    = '0;
    oe_ok   = !oe;
    for (int i = 0; i < 8; i++) begin
      nxt();
      bits = {bits[6:0], txd};
      if (oe) oe_ok = 1'b0;
    end
    check({nm, "_bits"}, 32'(bits), 32'(w));
    check({nm, "_oe_low_c0_c8"}, 32'(oe_ok), 32'(1));
    nxt();
    check({nm, "_idle_after"}, 32'({oe, busy}), 32'(2'b10));
    check({nm, "_txread_count"}, 32'(rd_cnt - r0), 32'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] w1, w2, bits;
    logic       lsb;
    logic [7:0] fifo[$];
    int         r0;

    txvalid = 1'b0;
    txdata  = '0;
    rst_n   = 1'b0;
    repeat (3) nxt();
    check("reset_outputs", 32'({fss, txd, oe, rd, busy}), 32'(5'b00100));
    rst_n = 1'b1;
    repeat (3) nxt();
    check("idle_without_valid", 32'(busy), 32'(0));

    // Isolated word
    tx_single(8'hA5, "a5");

    // Back-to-back 0x81 then 0x7E
    rd_cycles.delete();
    r0      = rd_cnt;
    txvalid = 1'b1;
    txdata  = 8'h81;
    nxt();
    check("b2b_c0_fss", 32'(fss), 32'(1));
    txdata = 8'h7E;
    w1     = '0;
    for (int i = 0; i < 8; i++) begin
      nxt();
      w1 = {w1[6:0], txd};
    end
    check("b2b_c8_fss", 32'(fss), 32'(1));
    check("b2b_c8_txread", 32'(rd), 32'(1));
    lsb     = txd;
    txvalid = 1'b0;
    txdata  = '0;
    w2      = '0;
    for (int i = 0; i < 8; i++) begin
      nxt();
      if (i == 0) check("b2b_msb_after_lsb", 32'({lsb, txd}), 32'(2'b10));
      w2 = {w2[6:0], txd};
    end
    check("b2b_second_c8_fss", 32'(fss), 32'(0));
    check("b2b_word1", 32'(w1), 32'(8'h81));
    check("b2b_word2", 32'(w2), 32'(8'h7E));
    nxt();
    check("b2b_idle_after", 32'(busy), 32'(0));
    check("b2b_txread_count", 32'(rd_cnt - r0), 32'(2));
    check("b2b_txread_events", 32'(rd_cycles.size()), 32'(2));
    if (rd_cycles.size() >= 2)
      check("b2b_txread_gap", 32'(rd_cycles[1] - rd_cycles[0]), 32'(8));

    // Loopback through the receiver, FIFO-driven
    rx_q.delete();
    rx_req_cnt = 0;
    r0   = rd_cnt;
    fifo = '{8'h00, 8'hFF, 8'h3C};
    for (int k = 0; k < 60 && rx_q.size() < 3; k++) begin
      txvalid = (fifo.size() != 0);
      txdata  = (fifo.size() != 0) ? fifo[0] : 8'h00;
      nxt();
      if (rd && fifo.size() != 0) void'(fifo.pop_front());
    end
    txvalid = 1'b0;
    txdata  = '0;
    repeat (2) nxt();
    check("loop_word_count", 32'(rx_q.size()), 32'(3));
    if (rx_q.size() == 3) begin
      check("loop_word0", 32'(rx_q[0]), 32'(8'h00));
      check("loop_word1", 32'(rx_q[1]), 32'(8'hFF));
      check("loop_word2", 32'(rx_q[2]), 32'(8'h3C));
    end
    check("loop_req_count", 32'(rx_req_cnt), 32'(3));
    check("loop_txread_count", 32'(rd_cnt - r0), 32'(3));

    // Reset in C4 of 0xF0, then 0x55
    r0      = rd_cnt;
    txvalid = 1'b1;
    txdata  = 8'hF0;
    nxt();
    txvalid = 1'b0;
    txdata  = '0;
    repeat (4) nxt();
    check("f0_c4_txd", 32'(txd), 32'(1));
    check("f0_c4_busy", 32'(busy), 32'(1));
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'({fss, txd, oe, rd, busy}), 32'(5'b00100));
    repeat (2) nxt();
    rst_n = 1'b1;
    repeat (10) nxt();
    check("reset_no_extra_txread", 32'(rd_cnt - r0), 32'(1));
    check("reset_stays_idle", 32'(busy), 32'(0));
    tx_single(8'h55, "post_reset_55");

    // TXVALID toggling in C2..C6 is ignored
    r0      = rd_cnt;
    txvalid = 1'b1;
    txdata  = 8'hC3;
    nxt();
    txvalid = 1'b0;
    bits    = '0;
    for (int k = 1; k <= 8; k++) begin
      nxt();
      bits    = {bits[6:0], txd};
      txvalid = (k <= 5) && (k % 2 == 1);
      txdata  = 8'hFF;
    end
    txvalid = 1'b0;
    nxt();
    check("toggle_bits", 32'(bits), 32'(8'hC3));
    check("toggle_txread_count", 32'(rd_cnt - r0), 32'(1));
    check("toggle_idle_after", 32'(busy), 32'(0));

    // TXVALID high through C6, low at the edge ending C7
    r0      = rd_cnt;
    txvalid = 1'b1;
    txdata  = 8'h96;
    nxt();
    txdata = 8'h5A;
    bits   = '0;
    for (int k = 1; k <= 8; k++) begin
      nxt();
      bits = {bits[6:0], txd};
      if (k == 8) begin
        check("drop_c8_fss", 32'(fss), 32'(0));
        check("drop_c8_txread", 32'(rd), 32'(0));
      end
      txvalid = (k <= 5);
    end
    txvalid = 1'b0;
    txdata  = '0;
    nxt();
    check("drop_after_c8", 32'({oe, busy}), 32'(2'b10));
    check("drop_bits", 32'(bits), 32'(8'h96));
    check("drop_txread_count", 32'(rd_cnt - r0), 32'(1));

    done = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
